seg7_decoder: RTL and testbench
===============================

// Module: seg7_decoder
// PURPOSE
//  Receive-side counterpart of the multiplexed 7-segment driver. Samples the time-multiplexed
//  segment and digit-select lines, then recovers the four BCD digits (ones..thousands).
//  Intended for loopback self-check and board-level monitoring of display output.
//  Output values are filtered for settling glitches and aged out when a digit stops refreshing.
// PARAMETERS
//  SETTLE_CYCLES   16       consecutive identical synced samples required before capture (>=2)
//  TIMEOUT_CYCLES  800_000  cycles without refresh before a position's valid bit drops (2 frames)
//  TO_W            20       width of each timeout counter; must hold TIMEOUT_CYCLES
// PORTS
//  clk_100MHz   in   1  system clock
//  reset_n      in   1  asynchronous, active-low reset
//  seg          in   [0:6] active-low segments, seg[0]=a .. seg[6]=g
//  digit        in   4  active-low digit select; bit0=ones .. bit3=thousands
//  ones         out  4  recovered BCD ones digit
//  tens         out  4  recovered BCD tens digit
//  hundreds     out  4  recovered BCD hundreds digit
//  thousands    out  4  recovered BCD thousands digit
//  digit_valid  out  4  per-position valid; bit order as digit
//  frame_done   out  1  1-cycle pulse when all four positions have been captured since the last pulse
//  pattern_err  out  1  1-cycle pulse on capture of an undecodable segment pattern
// BEHAVIOUR
//  Reset: all digit outputs 0, digit_valid 0, frame_done 0, pattern_err 0, captured mask 0,
//   timeout counters 0, and sync flops all-1s (inactive). State is WAIT.
//  Sync: seg and digit each pass through a 2-FF synchronizer. All logic below uses the synced copies.
//  Legal select: digit_s is one of 1110, 1101, 1011, 0111. Any other value is idle or illegal.
//  FSM:
//   WAIT   -> SETTLE when digit_s is legal. Stable counter = 0.
//   SETTLE -> the stable counter increments while {seg_s,digit_s} equals the previous cycle's value;
//             any change resets it to 0. If digit_s becomes illegal, go to WAIT.
//             When the counter reaches SETTLE_CYCLES-1, capture and go to HOLD.
//   HOLD   -> on any change of {seg_s,digit_s}: go to SETTLE if digit_s is legal, else WAIT.
//             There is no recapture while the value stays unchanged.
//  Capture (registered, visible on the next edge):
//   Decimal patterns: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100,
//             5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
//   On a decodable pattern: write the value to the selected position, set its digit_valid bit,
//   set its captured bit, and reload its timeout counter to 0.
//   On an undecodable pattern: pulse pattern_err, leave the value unchanged, and clear that position's
//   digit_valid and captured bits.
//  Latency: with inputs stable from edge N, the output updates at edge N+SETTLE_CYCLES+2.
//  frame_done: asserted the cycle after the captured mask becomes 1111. The mask clears in that same
//   cycle; a capture in that same cycle is counted into the new mask.
//  Timeout: each position's counter increments every cycle while its valid bit is 1. At
//   TIMEOUT_CYCLES-1 it clears digit_valid and captured for that position, and the counter stops at 0.
//   If capture and timeout hit the same position in the same cycle, capture wins.
//  Re-capture of an identical value still reloads the timeout counter; outputs do not glitch.
//  A reset_n assertion mid-capture aborts immediately; no partial update is ever visible.
// CONFIGURATION
//  SEG7_DEC_HEX_EN defined: the patterns below also decode, so outputs carry 4-bit hex.
//   A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
//  SEG7_DEC_HEX_EN undefined: those six patterns are undecodable and raise pattern_err.
// TESTING
//  1 Hold seg=0100100, digit=1110 for 100 cycles -> ones=5, digit_valid=0001 exactly 18 edges
//    after the input is applied (SETTLE_CYCLES=16).
//  2 Rotate digits 1110/1101/1011/0111 with values 1/2/3/4, each held 64 cycles
//    -> ones..thousands=1,2,3,4, digit_valid=1111, exactly one frame_done pulse per rotation.
//  3 On ones=5 with digit=1110 held, glitch seg to 0000000 for 5 cycles then restore
//    -> ones stays 5, no 8 is ever captured, no pattern_err.
//  4 seg=1111111 on digit=1101 held 64 cycles -> one pattern_err pulse, digit_valid[1]=0,
//    tens unchanged.
//  5 TIMEOUT_CYCLES=200: capture all four digits, then hold digit=1111
//    -> all digit_valid bits are 0 exactly 200 cycles after their last capture.
//  6 seg=0001000 on digit=0111: with SEG7_DEC_HEX_EN, thousands=4'hA and valid;
//    without it, pattern_err pulse and digit_valid[3]=0.
//  7 Pulse reset_n low mid-SETTLE -> all outputs 0 immediately, state WAIT, no capture afterwards
//    until a fresh settle completes.

Source files
------------

// File: rtl/seg7_decoder.sv
// Receive-side decoder for a multiplexed 7-segment display: recovers four BCD digits with
// settle filtering and per-position refresh timeout. Define SEG7_DEC_HEX_EN to also decode A..F.
module seg7_decoder #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 800_000,
  parameter int TO_W           = 20
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic [0:6] seg,
  input  logic [3:0] digit,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [3:0] hundreds,
  output logic [3:0] thousands,
  output logic [3:0] digit_valid,
  output logic       frame_done,
  output logic       pattern_err
);

  localparam int ST_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(SETTLE_CYCLES - 2);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_WAIT, ST_SETTLE, ST_HOLD} state_t;

  // Returns {decodable, value}; bit 6 of the pattern is segment a.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    r = 5'b0_0000;
    case (p)
      7'b0000001: r = 5'h10;
      7'b1001111: r = 5'h11;
      7'b0010010: r = 5'h12;
      7'b0000110: r = 5'h13;
      7'b1001100: r = 5'h14;
      7'b0100100: r = 5'h15;
      7'b0100000: r = 5'h16;
      7'b0001111: r = 5'h17;
      7'b0000000: r = 5'h18;
      7'b0000100: r = 5'h19;
`ifdef SEG7_DEC_HEX_EN
      7'b0001000: r = 5'h1A;
      7'b1100000: r = 5'h1B;
      7'b0110001: r = 5'h1C;
      7'b1000010: r = 5'h1D;
      7'b0110000: r = 5'h1E;
      7'b0111000: r = 5'h1F;
`endif
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  logic [6:0]           seg_s1_q, seg_s_q;
  logic [3:0]           dig_s1_q, dig_s_q;
  logic [10:0]          prev_q, cur;
  state_t               state_q, state_d;
  logic [ST_W-1:0]      stable_q, stable_d;
  logic [3:0][3:0]      val_q, val_d;
  logic [3:0]           valid_q, valid_d;
  logic [3:0]           mask_q, mask_d;
  logic [3:0][TO_W-1:0] to_cnt_q, to_cnt_d;
  logic                 frame_done_q, frame_done_d;
  logic                 pattern_err_q, pattern_err_d;
  logic                 legal, same, capture;
  logic [1:0]           sel;
  logic [4:0]           dec;

  assign cur  = {seg_s_q, dig_s_q};
  assign same = (cur == prev_q);
  assign dec  = decode(seg_s_q);

  always_comb begin
    legal = 1'b1;
    sel   = 2'd0;
    case (dig_s_q)
      4'b1110: sel = 2'd0;
      4'b1101: sel = 2'd1;
      4'b1011: sel = 2'd2;
      4'b0111: sel = 2'd3;
      default: legal = 1'b0;
    endcase
  end

  // Settle FSM: capture fires on the cycle the stable count would reach SETTLE_CYCLES-1.
  always_comb begin
    state_d  = state_q;
    stable_d = stable_q;
    capture  = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (legal) begin
          state_d  = ST_SETTLE;
          stable_d = '0;
        end
      end
      ST_SETTLE: begin
        if (!legal) begin
          state_d  = ST_WAIT;
          stable_d = '0;
        end else if (!same) begin
          stable_d = '0;
        end else if (stable_q == ST_LAST) begin
          capture  = 1'b1;
          state_d  = ST_HOLD;
          stable_d = '0;
        end else begin
          stable_d = stable_q + ST_W'(1);
        end
      end
      ST_HOLD: begin
        if (!same) begin
          state_d  = legal ? ST_SETTLE : ST_WAIT;
          stable_d = '0;
        end
      end
      default: begin
        state_d  = ST_WAIT;
        stable_d = '0;
      end
    endcase
  end

  // Capture, timeout and frame bookkeeping; capture is applied last so it wins over timeout.
  always_comb begin
    val_d         = val_q;
    valid_d       = valid_q;
    to_cnt_d      = to_cnt_q;
    pattern_err_d = 1'b0;
    frame_done_d  = (mask_q == 4'hF);
    mask_d        = (mask_q == 4'hF) ? 4'h0 : mask_q;
    for (int i = 0; i < 4; i++) begin
      if (valid_q[i]) begin
        if (to_cnt_q[i] == TO_LAST) begin
          valid_d[i]  = 1'b0;
          mask_d[i]   = 1'b0;
          to_cnt_d[i] = '0;
        end else begin
          to_cnt_d[i] = to_cnt_q[i] + TO_W'(1);
        end
      end
    end
    if (capture) begin
      to_cnt_d[sel] = '0;
      if (dec[4]) begin
        val_d[sel]   = dec[3:0];
        valid_d[sel] = 1'b1;
        mask_d[sel]  = 1'b1;
      end else begin
        pattern_err_d = 1'b1;
        valid_d[sel]  = 1'b0;
        mask_d[sel]   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      seg_s1_q      <= '1;
      seg_s_q       <= '1;
      dig_s1_q      <= '1;
      dig_s_q       <= '1;
      prev_q        <= '1;
      state_q       <= ST_WAIT;
      stable_q      <= '0;
      val_q         <= '0;
      valid_q       <= '0;
      mask_q        <= '0;
      to_cnt_q      <= '0;
      frame_done_q  <= 1'b0;
      pattern_err_q <= 1'b0;
    end else begin
      seg_s1_q      <= seg;
      seg_s_q       <= seg_s1_q;
      dig_s1_q      <= digit;
      dig_s_q       <= dig_s1_q;
      prev_q        <= cur;
      state_q       <= state_d;
      stable_q      <= stable_d;
      val_q         <= val_d;
      valid_q       <= valid_d;
      mask_q        <= mask_d;
      to_cnt_q      <= to_cnt_d;
      frame_done_q  <= frame_done_d;
      pattern_err_q <= pattern_err_d;
    end
  end

  assign ones        = val_q[0];
  assign tens        = val_q[1];
  assign hundreds    = val_q[2];
  assign thousands   = val_q[3];
  assign digit_valid = valid_q;
  assign frame_done  = frame_done_q;
  assign pattern_err = pattern_err_q;

endmodule

// File: tb/tb_seg7_decoder.sv
// Directed bench for seg7_decoder: a default instance plus a short-timeout instance on shared inputs.
module tb_seg7_decoder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [0:6] seg;
  logic [3:0] digit;

  logic [3:0] ones, tens, hundreds, thousands, valid;
  logic       frame_done, pattern_err;
  logic [3:0] t_ones, t_tens, t_hundreds, t_thousands, t_valid;
  logic       t_frame_done, t_pattern_err;

  int vec_cnt = 0;
  int err_cnt = 0;
  int fd_cnt = 0;
  int pe_cnt = 0;
  int eight_cnt = 0;
  int fd_base, pe_base, eight_base;

  localparam logic [6:0] P1 = 7'b1001111, P2 = 7'b0010010, P3 = 7'b0000110,
                         P4 = 7'b1001100, P5 = 7'b0100100, P7 = 7'b0001111,
                         P8 = 7'b0000000, PA = 7'b0001000, PBLANK = 7'b1111111;

  always #5 clk = ~clk;

  seg7_decoder dut (
    .clk_100MHz(clk), .reset_n(reset_n), .seg(seg), .digit(digit),
    .ones(ones), .tens(tens), .hundreds(hundreds), .thousands(thousands),
    .digit_valid(valid), .frame_done(frame_done), .pattern_err(pattern_err)
  );

  seg7_decoder #(.TIMEOUT_CYCLES(200)) dut_to (
    .clk_100MHz(clk), .reset_n(reset_n), .seg(seg), .digit(digit),
    .ones(t_ones), .tens(t_tens), .hundreds(t_hundreds), .thousands(t_thousands),
    .digit_valid(t_valid), .frame_done(t_frame_done), .pattern_err(t_pattern_err)
  );

  always @(negedge clk) begin
    if (frame_done)  fd_cnt++;
    if (pattern_err) pe_cnt++;
    if (ones == 4'd8) eight_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [6:0] s, input logic [3:0] d);
    seg   = s;
    digit = d;
  endtask

  initial begin
    reset_n = 1'b0;
    apply(PBLANK, 4'b1111);
    tick(3);
    chk("rst_ones", ones, 0);
    chk("rst_tens", tens, 0);
    chk("rst_hund", hundreds, 0);
    chk("rst_thou", thousands, 0);
    chk("rst_valid", valid, 0);
    chk("rst_pulses", {frame_done, pattern_err}, 0);
    reset_n = 1'b1;
    tick(2);

    // Exact capture latency
    apply(P5, 4'b1110);
    tick(17);
    chk("lat_ones_early", ones, 0);
    chk("lat_valid_early", valid, 4'b0000);
    tick(1);
    chk("lat_ones", ones, 5);
    chk("lat_valid", valid, 4'b0001);
    tick(82);

    // Digit rotation and frame pulses
    fd_base = fd_cnt;
    pe_base = pe_cnt;
    for (int r = 0; r < 2; r++) begin
      apply(P1, 4'b1110); tick(64);
      apply(P2, 4'b1101); tick(64);
      apply(P3, 4'b1011); tick(64);
      apply(P4, 4'b0111); tick(64);
      chk("rot_frame_done", fd_cnt - fd_base, 1);
      fd_base = fd_cnt;
    end
    chk("rot_ones", ones, 1);
    chk("rot_tens", tens, 2);
    chk("rot_hund", hundreds, 3);
    chk("rot_thou", thousands, 4);
    chk("rot_valid", valid, 4'b1111);
    chk("rot_no_err", pe_cnt - pe_base, 0);

    // Short glitch is filtered
    apply(P5, 4'b1110); tick(64);
    chk("glitch_pre", ones, 5);
    pe_base = pe_cnt;
    eight_base = eight_cnt;
    apply(P8, 4'b1110); tick(5);
    apply(P5, 4'b1110); tick(64);
    chk("glitch_ones", ones, 5);
    chk("glitch_no8", eight_cnt - eight_base, 0);
    chk("glitch_no_err", pe_cnt - pe_base, 0);

    // Undecodable blank pattern on tens
    pe_base = pe_cnt;
    apply(PBLANK, 4'b1101); tick(64);
    chk("blank_err", pe_cnt - pe_base, 1);
    chk("blank_valid1", valid[1], 0);
    chk("blank_tens", tens, 2);

    // Hex pattern A on thousands
    pe_base = pe_cnt;
    apply(PA, 4'b0111); tick(64);
`ifdef SEG7_DEC_HEX_EN
    chk("hex_thou", thousands, 4'hA);
    chk("hex_valid3", valid[3], 1);
    chk("hex_err", pe_cnt - pe_base, 0);
`else
    chk("hex_thou", thousands, 4);
    chk("hex_valid3", valid[3], 0);
    chk("hex_err", pe_cnt - pe_base, 1);
`endif

    // Timeout on the short-timeout instance: captures at +18, +38, +58, +78
    apply(P1, 4'b1110); tick(20);
    apply(P2, 4'b1101); tick(20);
    apply(P3, 4'b1011); tick(20);
    apply(P4, 4'b0111); tick(20);
    chk("to_all_valid", t_valid, 4'b1111);
    apply(PBLANK, 4'b1111);
    tick(137);
    chk("to_ones_edge", t_valid, 4'b1111);
    tick(1);
    chk("to_ones_drop", t_valid, 4'b1110);
    tick(59);
    chk("to_thou_edge", t_valid, 4'b1000);
    tick(1);
    chk("to_all_drop", t_valid, 4'b0000);

    // Reset in the middle of a settle
    apply(P7, 4'b1110);
    tick(8);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ones", ones, 0);
    chk("mid_rst_digits", {tens, hundreds, thousands}, 0);
    chk("mid_rst_valid", valid, 0);
    tick(2);
    reset_n = 1'b1;
    tick(17);
    chk("post_rst_early", {ones, valid}, 0);
    tick(1);
    chk("post_rst_ones", ones, 7);
    chk("post_rst_valid", valid, 4'b0001);
    tick(4);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
